// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execution sequencer.
//   DATA_W / ADDR_W : default operand and register-address widths
//   opcode_t        : 3-bit instruction opcodes
//   state_t         : sequencer states (IDLE -> LOAD -> EXEC -> WB)
//   ST_N/ST_Z/ST_V  : bit positions of the flags inside status
//   writes_back()   : opcode produces a register write
//   updates_flags() : opcode updates the status register
package exec_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  typedef enum logic [2:0] {
    OP_MOVI = 3'b000,
    OP_MOV  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVN  = 3'b101,
    OP_CMP  = 3'b110,
    OP_NOP  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam int ST_N = 2;
  localparam int ST_Z = 1;
  localparam int ST_V = 0;

  function automatic logic writes_back(input opcode_t op);
    return !(op == OP_CMP || op == OP_NOP);
  endfunction

  // MOV, MOVI and NOP leave the flags alone.
  function automatic logic updates_flags(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_MVN) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/exec_sequencer_alu_unit.sv
// alu_unit: purely combinational ALU of the execution sequencer.
//   a, b    : operands (b is already shifted when the shifter is enabled)
//   opcode  : operation select
//   imm     : immediate, used by MOVI
//   c       : result (two's complement, modulo 2^DATA_W)
//   n, z, v : negative, zero and signed-overflow flags of c
module alu_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = exec_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_t           opcode,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] c,
  output logic              n,
  output logic              z,
  output logic              v
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    c = '0;
    v = 1'b0;
    case (opcode)
      OP_MOVI: c = imm;
      OP_MOV:  c = b;
      OP_ADD: begin
        c = sum;
        // Like-signed operands producing an opposite-signed sum.
        v = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        c = diff;
        // Unlike-signed operands where the sign of the difference flips from a.
        v = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  c = a & b;
      OP_MVN:  c = ~b;
      default: c = '0;
    endcase
  end

  assign n = c[DATA_W-1];
  assign z = (c == '0);

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: four-state execution stage behind a register file.
//   clk, reset         : clock, asynchronous active-high reset
//   start + opcode/rd/rn/rm/imm/shift : instruction, sampled only in IDLE
//   rA, rB / dataA, dataB : register-file read port (data is combinational)
//   wr_en, wr_addr, wr_data : one-cycle write-back request
//   result_q, status   : last result and {N,Z,V} flags
//   busy, done         : state != IDLE, one-cycle completion pulse
// Build option: define EXEC_SEQUENCER_SHIFTER_EN to enable the B-operand
// shifter (00 none, 01 LSL1, 10 LSR1, 11 ASR1); otherwise shift is ignored.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int DATA_W = exec_pkg::DATA_W,
  parameter int ADDR_W = exec_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [DATA_W-1:0] imm,
  input  logic [1:0]        shift,
  output logic [ADDR_W-1:0] rA,
  output logic [ADDR_W-1:0] rB,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] result_q,
  output logic [2:0]        status,
  output logic              busy,
  output logic              done
);

  state_t            state_reg, state_next;
  opcode_t           opcode_reg;
  logic [ADDR_W-1:0] rd_reg, rn_reg, rm_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [DATA_W-1:0] b_shift;
  logic              wr_en_next, done_next;
  logic [DATA_W-1:0] alu_c;
  logic              alu_n, alu_z, alu_v;

`ifdef EXEC_SEQUENCER_SHIFTER_EN
  logic [1:0] shift_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      shift_reg <= 2'b00;
    else if (state_reg == S_IDLE && start)
      shift_reg <= shift;
  end

  always_comb begin
    case (shift_reg)
      2'b01:   b_shift = {b_reg[DATA_W-2:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_reg[DATA_W-1:1]};
      2'b11:   b_shift = {b_reg[DATA_W-1], b_reg[DATA_W-1:1]};
      default: b_shift = b_reg;
    endcase
  end
`else
  logic [1:0] shift_unused;
  assign shift_unused = shift;
  assign b_shift      = b_reg;
`endif

  alu_unit #(.DATA_W(DATA_W)) u_alu (
    .a      (a_reg),
    .b      (b_shift),
    .opcode (opcode_reg),
    .imm    (imm_reg),
    .c      (alu_c),
    .n      (alu_n),
    .z      (alu_z),
    .v      (alu_v)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: read addresses follow the latched instruction while busy;
  // the write-back strobes are registered, so they appear in the cycle after WB.
  always_comb begin
    busy       = (state_reg != S_IDLE);
    rA         = '0;
    rB         = '0;
    wr_en_next = 1'b0;
    done_next  = 1'b0;
    if (busy) begin
      rA = rn_reg;
      rB = rm_reg;
    end
    if (state_reg == S_WB) begin
      done_next  = 1'b1;
      wr_en_next = writes_back(opcode_reg);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_reg <= OP_MOVI;
      rd_reg     <= '0;
      rn_reg     <= '0;
      rm_reg     <= '0;
      imm_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_q   <= '0;
      status     <= '0;
      wr_en      <= 1'b0;
      done       <= 1'b0;
      wr_addr    <= '0;
    end else begin
      if (state_reg == S_IDLE && start) begin
        opcode_reg <= opcode_t'(opcode);
        rd_reg     <= rd;
        rn_reg     <= rn;
        rm_reg     <= rm;
        imm_reg    <= imm;
      end
      if (state_reg == S_LOAD) begin
        a_reg <= dataA;
        b_reg <= dataB;
      end
      if (state_reg == S_EXEC) begin
        if (writes_back(opcode_reg))
          result_q <= alu_c;
        if (updates_flags(opcode_reg)) begin
          status[ST_N] <= alu_n;
          status[ST_Z] <= alu_z;
          status[ST_V] <= alu_v;
        end
      end
      if (state_reg == S_WB)
        wr_addr <= rd_reg;
      wr_en <= wr_en_next;
      done  <= done_next;
    end
  end

  assign wr_data = result_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed, table-driven bench for exec_sequencer.
module tb_exec_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] rd, rn, rm, shift;
  logic [7:0] imm;
  logic [1:0] rA, rB;
  logic [7:0] dataA, dataB;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data, result_q;
  logic [2:0] status;
  logic       busy, done;

  logic [7:0] rf [4];
  assign dataA = rf[rA];
  assign dataB = rf[rB];

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .rd(rd), .rn(rn), .rm(rm), .imm(imm), .shift(shift),
    .rA(rA), .rB(rB), .dataA(dataA), .dataB(dataB),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .result_q(result_q), .status(status), .busy(busy), .done(done)
  );

`ifdef EXEC_SEQUENCER_SHIFTER_EN
  localparam logic [7:0] MOV_EXP = 8'hC2;
`else
  localparam logic [7:0] MOV_EXP = 8'h84;
`endif

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd, rn, rm, sh;
    logic [7:0] imm, a, b;
    logic       exp_we;
    logic [7:0] exp_c;
    logic [2:0] exp_st;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] d, input logic [1:0] n,
                       input logic [1:0] m, input logic [7:0] im, input logic [1:0] sh);
    opcode = op; rd = d; rn = n; rm = m; imm = im; shift = sh;
    start  = 1'b1;
  endtask

  initial begin
    logic seen_we;
    reset = 1'b1; start = 1'b0; opcode = '0; rd = '0; rn = '0; rm = '0;
    imm = '0; shift = '0;
    for (int i = 0; i < 4; i++) rf[i] = '0;

    //            op    rd    rn    rm    sh     imm    a      b      we    c        st
    vecs[0]  = '{3'd0, 2'd1, 2'd0, 2'd0, 2'd3, 8'h7F, 8'h00, 8'h00, 1'b1, 8'h7F,   3'b000}; // MOVI
    vecs[1]  = '{3'd2, 2'd2, 2'd0, 2'd1, 2'd0, 8'h00, 8'h7F, 8'h01, 1'b1, 8'h80,   3'b101}; // ADD ovf
    vecs[2]  = '{3'd6, 2'd0, 2'd2, 2'd3, 2'd0, 8'h00, 8'h05, 8'h05, 1'b0, 8'h80,   3'b010}; // CMP eq
    vecs[3]  = '{3'd3, 2'd3, 2'd1, 2'd2, 2'd0, 8'h00, 8'h80, 8'h01, 1'b1, 8'h7F,   3'b001}; // SUB ovf
    vecs[4]  = '{3'd4, 2'd0, 2'd3, 2'd0, 2'd0, 8'h00, 8'hF0, 8'h0F, 1'b1, 8'h00,   3'b010}; // AND
    vecs[5]  = '{3'd5, 2'd1, 2'd0, 2'd2, 2'd0, 8'h00, 8'h00, 8'h55, 1'b1, 8'hAA,   3'b100}; // MVN
    vecs[6]  = '{3'd1, 2'd2, 2'd0, 2'd3, 2'd3, 8'h00, 8'h00, 8'h84, 1'b1, MOV_EXP, 3'b100}; // MOV shift
    vecs[7]  = '{3'd7, 2'd3, 2'd0, 2'd1, 2'd0, 8'h00, 8'h11, 8'h22, 1'b0, MOV_EXP, 3'b100}; // NOP
    vecs[8]  = '{3'd2, 2'd3, 2'd1, 2'd1, 2'd0, 8'h00, 8'hFF, 8'hFF, 1'b1, 8'hFE,   3'b100}; // ADD rn==rm
    vecs[9]  = '{3'd3, 2'd0, 2'd0, 2'd2, 2'd0, 8'h00, 8'h05, 8'h05, 1'b1, 8'h00,   3'b010}; // SUB rd==rn
    vecs[10] = '{3'd6, 2'd1, 2'd1, 2'd2, 2'd0, 8'h00, 8'h03, 8'h05, 1'b0, 8'h00,   3'b100}; // CMP lt
    vecs[11] = '{3'd2, 2'd2, 2'd0, 2'd3, 2'd0, 8'h00, 8'h80, 8'h80, 1'b1, 8'h00,   3'b011}; // ADD wrap

    // Reset state
    tick(); tick();
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_wr_en", {7'b0, wr_en}, 8'h00);
    check("rst_done", {7'b0, done}, 8'h00);
    check("rst_result", result_q, 8'h00);
    check("rst_status", {5'b0, status}, 8'h00);
    check("rst_rA", {6'b0, rA}, 8'h00);
    reset = 1'b0;
    tick();

    // Table-driven instructions
    for (int i = 0; i < 12; i++) begin
      rf[vecs[i].rn] = vecs[i].a;
      rf[vecs[i].rm] = vecs[i].b;
      issue(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, vecs[i].sh);
      tick();                                   // LOAD
      start = 1'b0;
      check("load_busy", {7'b0, busy}, 8'h01);
      check("load_rA", {6'b0, rA}, {6'b0, vecs[i].rn});
      check("load_rB", {6'b0, rB}, {6'b0, vecs[i].rm});
      tick();                                   // EXEC
      tick();                                   // WB
      check("wb_wr_en_early", {7'b0, wr_en}, 8'h00);
      check("wb_busy", {7'b0, busy}, 8'h01);
      tick();                                   // strobes visible
      check("done", {7'b0, done}, 8'h01);
      check("wr_en", {7'b0, wr_en}, {7'b0, vecs[i].exp_we});
      if (vecs[i].exp_we) check("wr_addr", {6'b0, wr_addr}, {6'b0, vecs[i].rd});
      check("wr_data", wr_data, vecs[i].exp_c);
      check("result_q", result_q, vecs[i].exp_c);
      check("status", {5'b0, status}, {5'b0, vecs[i].exp_st});
      check("idle_busy", {7'b0, busy}, 8'h00);
      $display("[TB] vec %0d op=%0d wr_en=%0b wr_data=%h status=%b", i, vecs[i].op, wr_en, wr_data, status);
      tick();
      check("done_pulse", {7'b0, done}, 8'h00);
    end

    // Back-to-back: start held high through SUB and the following AND
    rf[2] = 8'h10; rf[3] = 8'h03; rf[0] = 8'h3C; rf[1] = 8'h0F;
    issue(3'd3, 2'd1, 2'd2, 2'd3, 8'h00, 2'd0);
    tick();                                     // SUB LOAD
    opcode = 3'd4; rd = 2'd2; rn = 2'd0; rm = 2'd1;  // AND waits, start stays high
    tick();                                     // EXEC
    check("b2b_ignored_rA", {6'b0, rA}, 8'h02);
    tick();                                     // WB
    check("b2b_wb_busy", {7'b0, busy}, 8'h01);
    tick();                                     // IDLE gap
    check("b2b_gap_busy", {7'b0, busy}, 8'h00);
    check("b2b_sub_wr_en", {7'b0, wr_en}, 8'h01);
    check("b2b_sub_data", wr_data, 8'h0D);
    $display("[TB] b2b SUB wr_data=%h busy=%0b", wr_data, busy);
    tick();                                     // AND LOAD
    start = 1'b0;
    check("b2b_and_busy", {7'b0, busy}, 8'h01);
    check("b2b_and_rA", {6'b0, rA}, 8'h00);
    tick(); tick(); tick();
    check("b2b_and_wr_en", {7'b0, wr_en}, 8'h01);
    check("b2b_and_addr", {6'b0, wr_addr}, 8'h02);
    check("b2b_and_data", wr_data, 8'h0C);
    check("b2b_and_status", {5'b0, status}, 8'h00);
    $display("[TB] b2b AND wr_data=%h status=%b", wr_data, status);
    tick();

    // Reset during EXEC of ADD rd=2
    rf[0] = 8'h01; rf[1] = 8'h02;
    issue(3'd2, 2'd2, 2'd0, 2'd1, 8'h00, 2'd0);
    tick();                                     // LOAD
    start = 1'b0;
    tick();                                     // EXEC
    reset = 1'b1;
    #1;
    check("abort_busy", {7'b0, busy}, 8'h00);
    check("abort_rA", {6'b0, rA}, 8'h00);
    check("abort_result", result_q, 8'h00);
    check("abort_status", {5'b0, status}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    seen_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (wr_en || done) seen_we = 1'b1;
    end
    check("abort_no_wb", {7'b0, seen_we}, 8'h00);
    $display("[TB] abort busy=%0b wr_en_seen=%0b", busy, seen_we);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
